// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier scheduler.
// Holds the controller state encoding and default sizing constants.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 2;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub on {Q[0],q_1},
// then arithmetic right shift of {A,Q,q_1}.
module booth_step #(
  parameter int W = 8
) (
  input  logic [W:0]   i_a,
  input  logic [W-1:0] i_q,
  input  logic         i_q1,
  input  logic [W:0]   i_m,
  output logic [W:0]   o_a,
  output logic [W-1:0] o_q,
  output logic         o_q1
);

  logic [W:0] w_sum;

  always_comb begin
    w_sum = i_a;
    unique case ({i_q[0], i_q1})
      2'b10:   w_sum = i_a - i_m;
      2'b01:   w_sum = i_a + i_m;
      default: w_sum = i_a;
    endcase
  end

  assign o_a  = {w_sum[W], w_sum[W:1]};
  assign o_q  = {w_sum[0], i_q[W-1:1]};
  assign o_q1 = i_q[0];

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin shared radix-2 Booth multiplier.
// One op in flight; a bubble IDLE cycle separates ops.
module booth_mul_sched
  import booth_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NREQ  = DEF_NREQ,
  localparam int IDW   = id_w(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH-1:0]      out_product,
  output logic [IDW-1:0]          out_id,
  output logic                    busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [WIDTH:0]   r_m;
  logic             r_valid;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_last;

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gidx;
  logic             w_found;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_na;
  logic [WIDTH-1:0] w_nq;
  logic             w_nq1;

  // Search order starts one past the last granted requester.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && req_valid[i] &&
            (i == (int'(r_last) + 1 + k) % NREQ)) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_gidx     = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_a = req_a[i*WIDTH +: WIDTH];
        w_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  booth_step #(
    .W (WIDTH)
  ) u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_na),
    .o_q  (w_nq),
    .o_q1 (w_nq1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_m     <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_last  <= IDW'(NREQ - 1);
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_last  <= w_gidx;
            r_id    <= w_gidx;
            r_a     <= '0;
            r_q     <= w_b;
            r_q1    <= 1'b0;
            r_m     <= {w_a[WIDTH-1], w_a};
            r_cnt   <= CW'(WIDTH);
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= w_na;
          r_q   <= w_nq;
          r_q1  <= w_nq1;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE) ? w_grant : '0;
  assign busy        = (r_state != IDLE);
  assign out_valid   = r_valid;
  assign out_product = {r_a[WIDTH-1:0], r_q};
  assign out_id      = r_id;

endmodule
